// File: rtl/fp_norm_pkg.sv
// Shared widths, limits and FSM state type for the FP normalization sequencer.
package fp_norm_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int RAW_W  = 25;
   localparam int SFR_W  = 6;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {IDLE, DETECT, SHIFT, PACK, DONE} state_t;

endpackage

// File: rtl/fp_norm_seq_lz_shift_enc.sv
// Leading-one encoder: signed shift needed to bring the leading one to bit 23.
// Bit 24 gives +1, bit 0 gives -23; an all-zero mantissa reports -1.
module lz_shift_enc
   import fp_norm_pkg::*;
(
   input  logic [RAW_W-1:0]        mant,
   output logic signed [SFR_W-1:0] sfr
);

   always_comb begin
      sfr = SFR_W'(-1);
      for (int i = 0; i < RAW_W; i++) begin
         if (mant[i]) sfr = SFR_W'(i - (RAW_W - 2));
      end
   end

endmodule

// File: rtl/fp_norm_seq.sv
// Multi-cycle normalizer for the FP add/sub datapath: detect, shift MAX_STEP bits
// per cycle, pack. Optional macro FP_NORM_ROUND_EN enables RNE on the right-shift path.
module fp_norm_seq
   import fp_norm_pkg::*;
#(
   parameter int MAX_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [RAW_W-1:0]  in_mant,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W-1:0]  out_exp,
   output logic [MANT_W-1:0] out_mant,
   output logic              out_zero,
   output logic              out_ovf,
   output logic              out_unf,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready, and the payload is held stable while valid waits.

   localparam logic [4:0] STEP = 5'(MAX_STEP);

   state_t state, state_nxt;

   logic                    sign_r;
   logic [EXP_W-1:0]        exp_in_r;
   logic [RAW_W-1:0]        mant_r;
   logic [EXP_W-1:0]        e_r;
   logic [4:0]              rem_r;
   logic                    right_r, zero_r, ovf_r, unf_r;
`ifdef FP_NORM_ROUND_EN
   logic                    guard_r;
`endif

   logic signed [SFR_W-1:0] sfr;
   logic signed [9:0]       e_det;
   logic                    zero_det, ovf_det, unf_det, bypass;
   logic [4:0]              step;
   logic                    round_up;
   logic [MANT_W:0]         frac_rnd;
   logic [EXP_W:0]          exp_rnd;

   lz_shift_enc u_enc (.mant(mant_r), .sfr(sfr));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   always_comb begin
      e_det    = $signed({2'b00, exp_in_r}) + $signed({{(10-SFR_W){sfr[SFR_W-1]}}, sfr});
      zero_det = (mant_r == '0);
      ovf_det  = !zero_det && (e_det >= 10'sd255);
      unf_det  = !zero_det && !ovf_det && (e_det <= 10'sd0);
      bypass   = zero_det || ovf_det || unf_det || (sfr == '0);
      step     = (rem_r > STEP) ? STEP : rem_r;
`ifdef FP_NORM_ROUND_EN
      round_up = guard_r & mant_r[0];
`else
      round_up = 1'b0;
`endif
      // A rounding carry out of the fraction leaves it zero and bumps the exponent.
      frac_rnd = {1'b0, mant_r[MANT_W-1:0]} + {{MANT_W{1'b0}}, round_up};
      exp_rnd  = {1'b0, e_r} + {{EXP_W{1'b0}}, frac_rnd[MANT_W]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = DETECT;
         DETECT:  state_nxt = bypass ? PACK : SHIFT;
         SHIFT:   if (right_r || (rem_r == step)) state_nxt = PACK;
         PACK:    state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_r   <= 1'b0;
         exp_in_r <= '0;
         mant_r   <= '0;
         e_r      <= '0;
         rem_r    <= '0;
         right_r  <= 1'b0;
         zero_r   <= 1'b0;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
`ifdef FP_NORM_ROUND_EN
         guard_r  <= 1'b0;
`endif
         out_sign <= 1'b0;
         out_exp  <= '0;
         out_mant <= '0;
         out_zero <= 1'b0;
         out_ovf  <= 1'b0;
         out_unf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_r   <= in_sign;
                  exp_in_r <= in_exp;
                  mant_r   <= in_mant;
               end
            end
            DETECT: begin
               e_r     <= e_det[EXP_W-1:0];
               zero_r  <= zero_det;
               ovf_r   <= ovf_det;
               unf_r   <= unf_det;
               right_r <= (sfr == SFR_W'(1));
               rem_r   <= 5'(-sfr);
`ifdef FP_NORM_ROUND_EN
               guard_r <= 1'b0;
`endif
            end
            SHIFT: begin
               if (right_r) begin
                  mant_r  <= mant_r >> 1;
`ifdef FP_NORM_ROUND_EN
                  guard_r <= mant_r[0];
`endif
               end else begin
                  mant_r <= mant_r << step;
                  rem_r  <= rem_r - step;
               end
            end
            PACK: begin
               out_sign <= sign_r;
               out_exp  <= '0;
               out_mant <= '0;
               out_zero <= 1'b0;
               out_ovf  <= 1'b0;
               out_unf  <= 1'b0;
               if (zero_r) begin
                  out_zero <= 1'b1;
               end else if (ovf_r || (exp_rnd >= {1'b0, EXP_MAX})) begin
                  out_exp <= EXP_MAX;
                  out_ovf <= 1'b1;
               end else if (unf_r) begin
                  out_unf <= 1'b1;
               end else begin
                  out_exp  <= exp_rnd[EXP_W-1:0];
                  out_mant <= frac_rnd[MANT_W-1:0];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_sign <= 1'b0;
                  out_exp  <= '0;
                  out_mant <= '0;
                  out_zero <= 1'b0;
                  out_ovf  <= 1'b0;
                  out_unf  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
